seven_segment_capture: RTL and testbench
========================================

// Module: seven_segment_capture
// PURPOSE
//  Receive side of the 4-digit multiplexed 7-segment interface. Samples the active-low
//  anode strobes and active-low segment bus, waits for each digit dwell to settle, and
//  decodes the pattern back to a 4-bit code per digit. A code is committed only after
//  repeated agreement, then exported with valid and change flags.
//  Used for on-board self-check of the score display: digit 0 = cpu score, digit 3 = player score.
// PARAMETERS
//  SETTLE   4        consecutive identical registered cycles before one capture is taken
//  CONFIRM  2        consecutive identical captures of one digit before commit (>=1)
//  TIMEOUT  1048575  cycles without a capture before a digit is invalidated (counter $clog2(TIMEOUT+1) bits)
// PORTS
//  clk           in   1   system clock, all logic on posedge
//  rst           in   1   synchronous active-high reset
//  seg_in        in   7   segments, active-low, [6]=A ... [0]=G
//  an_in         in   4   anodes, active-low one-hot, an_in[n]=0 selects digit n
//  digits        out  16  committed codes, digit n at [4n+3:4n]
//  digit_valid   out  4   digit n holds a committed, unexpired code
//  change        out  1   1-cycle pulse when any committed digit or valid bit changes
//  changed_mask  out  4   digits that changed this cycle; meaningful only with change=1, else 0
//  an_err        out  1   1-cycle pulse: settled anode pattern had more than one low bit
// BEHAVIOUR
//  - Reset (next edge): digits=16'hFFFF, digit_valid=0, change=0, changed_mask=0, an_err=0;
//    input regs an_q=4'hF, seg_q=7'h7F; stable count, candidates, confirm and watchdog counters 0.
//    rst mid-dwell or mid-confirm discards all partial progress.
//  - Stage 1: an_in/seg_in registered into an_q/seg_q every cycle.
//  - Settle: stable_cnt clears when {an_q,seg_q} differs from its previous-cycle value,
//    else increments saturating at SETTLE. Capture pulse fires exactly once per dwell, in
//    the cycle stable_cnt becomes SETTLE. Dwell shorter than SETTLE cycles: no capture.
//  - At capture: an_q==4'hF -> ignored (blanking, no error); exactly one low bit -> digit
//    capture; two or more low -> an_err pulse next edge, no capture, nothing else changes.
//  - Decode seg_q: 0000001=0 1001111=1 0010010=2 0000110=3 1001100=4 0100100=5
//    0100000=6 0001111=7 0000000=8 0001100=9 1111110=4'hE(dash) 1111111=4'hB(blank),
//    any other pattern=4'hF(invalid). All codes go through confirm identically.
//  - Confirm, digit n: code==cand_n -> conf_n saturating ++ (max CONFIRM); else cand_n=code,
//    conf_n=1. When conf_n equals CONFIRM after this capture: digits[n] and digit_valid[n]=1
//    update on the next edge; if code differs from old digit or old valid was 0, set
//    changed_mask[n] and change for that one cycle. Re-commit of same code: no pulse.
//  - Latency: commit visible 1 cycle after the confirming capture.
//  - Watchdog n: cleared on every capture of digit n (committed or not), saturates at TIMEOUT.
//    On reaching TIMEOUT: digit n=4'hF, valid[n]=0, cand_n/conf_n cleared; change and
//    changed_mask[n] pulse only if valid[n] was 1.
//  - Simultaneous timeout of one digit and commit of another: both bits in one changed_mask,
//    single change pulse. Only one digit can capture per cycle.
// TESTING (SETTLE=4, CONFIRM=2, TIMEOUT=64)
//  1 rst=1 two cycles mid-stream -> digits=FFFF, digit_valid=0, change/changed_mask/an_err=0.
//  2 an=1110 seg=0010010 8 cycles, an=1111 4 cycles, repeat -> digits[3:0]=2, valid=0001,
//    one change pulse with changed_mask=0001 after 2nd dwell only; a 3rd dwell gives no pulse.
//  3 an=1101 seg=1001111 held 3 cycles, alternated with blank -> no capture, digits unchanged.
//  4 sweep all 10 digit patterns plus 1111110, 1111111, 1010101 on digit 1, two dwells each
//    -> digits[7:4]=0..9,E,B,F in order, one change pulse per new code.
//  5 an=1100 seg=0000000 8 cycles -> one an_err pulse, digits/valid unchanged, no change.
//  6 commit 7 on digit 3, then only blank dwells 64+ cycles -> valid[3]=0, digits[15:12]=F,
//    change with changed_mask=1000; digit 0 committed in parallel refreshed: stays valid.
//  7 digit 2 alternating 5,6 each dwell -> never commits, valid[2]=0, no change pulse.

Source files
------------

// File: rtl/seven_segment_capture_if.sv
// Bundle of the multiplexed 7-segment receive signals and the decoded
// digit outputs of seven_segment_capture.
interface seven_segment_capture_if;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        change;
    logic [3:0]  changed_mask;
    logic        an_err;

    modport master (
        output seg_in, an_in,
        input  digits, digit_valid, change, changed_mask, an_err
    );

    modport slave (
        input  seg_in, an_in,
        output digits, digit_valid, change, changed_mask, an_err
    );
endinterface

// File: rtl/seven_segment_capture.sv
// Receive side of a 4-digit multiplexed 7-segment display: settles each
// dwell, decodes the segments and commits a digit after repeated agreement.
module seven_segment_capture #(
    parameter int SETTLE  = 4,
    parameter int CONFIRM = 2,
    parameter int TIMEOUT = 1048575
) (
    input logic clk,
    input logic rst,
    seven_segment_capture_if.slave bus
);
    localparam int SW = $clog2(SETTLE + 1);
    localparam int CW = $clog2(CONFIRM + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic [10:0]   prev_q, prev_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [3:0]    cand_q [4];
    logic [3:0]    cand_d [4];
    logic [CW-1:0] conf_q [4];
    logic [CW-1:0] conf_d [4];
    logic [WW-1:0] wd_q [4];
    logic [WW-1:0] wd_d [4];
    logic [15:0]   digits_q, digits_d;
    logic [3:0]    valid_q, valid_d;
    logic          change_q, change_d;
    logic [3:0]    mask_q, mask_d;
    logic          an_err_q, an_err_d;

    logic          capture;
    logic [3:0]    an_low;
    logic          one_low;
    logic          multi_low;
    logic [3:0]    code;
    logic [3:0]    cap_vec;
    logic          expire;

    always_comb begin
        an_d     = bus.an_in;
        seg_d    = bus.seg_in;
        prev_d   = {an_q, seg_q};
        stable_d = stable_q;
        capture  = 1'b0;
        if ({an_q, seg_q} != prev_q) begin
            stable_d = '0;
        end else if (stable_q != SW'(SETTLE)) begin
            stable_d = stable_q + 1'b1;
            capture  = (stable_q == SW'(SETTLE - 1));
        end

        an_low    = ~an_q;
        one_low   = (an_low != 4'h0) && ((an_low & (an_low - 4'h1)) == 4'h0);
        multi_low = (an_low != 4'h0) && !one_low;
        an_err_d  = capture && multi_low;
        cap_vec   = (capture && one_low) ? an_low : 4'h0;

        case (seg_q)
            7'b0000001: code = 4'h0;
            7'b1001111: code = 4'h1;
            7'b0010010: code = 4'h2;
            7'b0000110: code = 4'h3;
            7'b1001100: code = 4'h4;
            7'b0100100: code = 4'h5;
            7'b0100000: code = 4'h6;
            7'b0001111: code = 4'h7;
            7'b0000000: code = 4'h8;
            7'b0001100: code = 4'h9;
            7'b1111110: code = 4'hE;
            7'b1111111: code = 4'hB;
            default:    code = 4'hF;
        endcase

        digits_d = digits_q;
        valid_d  = valid_q;
        mask_d   = 4'h0;
        expire   = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cand_d[n] = cand_q[n];
            conf_d[n] = conf_q[n];
            wd_d[n]   = wd_q[n];
            expire    = 1'b0;
            if (cap_vec[n]) begin
                wd_d[n] = '0;
                if (code == cand_q[n]) begin
                    if (conf_q[n] != CW'(CONFIRM))
                        conf_d[n] = conf_q[n] + 1'b1;
                end else begin
                    cand_d[n] = code;
                    conf_d[n] = CW'(1);
                end
                if (conf_d[n] == CW'(CONFIRM)) begin
                    digits_d[4*n +: 4] = code;
                    valid_d[n]         = 1'b1;
                    if (!valid_q[n] || digits_q[4*n +: 4] != code)
                        mask_d[n] = 1'b1;
                end
            end else if (wd_q[n] != WW'(TIMEOUT)) begin
                wd_d[n] = wd_q[n] + 1'b1;
                expire  = (wd_q[n] == WW'(TIMEOUT - 1));
            end
            // Watchdog expiry drops both the committed code and confirm progress
            if (expire) begin
                digits_d[4*n +: 4] = 4'hF;
                valid_d[n]         = 1'b0;
                cand_d[n]          = 4'h0;
                conf_d[n]          = '0;
                mask_d[n]          = valid_q[n];
            end
        end
        change_d = |mask_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q     <= 4'hF;
            seg_q    <= 7'h7F;
            prev_q   <= {4'hF, 7'h7F};
            stable_q <= '0;
            for (int n = 0; n < 4; n++) begin
                cand_q[n] <= 4'h0;
                conf_q[n] <= '0;
                wd_q[n]   <= '0;
            end
            digits_q <= 16'hFFFF;
            valid_q  <= 4'h0;
            change_q <= 1'b0;
            mask_q   <= 4'h0;
            an_err_q <= 1'b0;
        end else begin
            an_q     <= an_d;
            seg_q    <= seg_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            for (int n = 0; n < 4; n++) begin
                cand_q[n] <= cand_d[n];
                conf_q[n] <= conf_d[n];
                wd_q[n]   <= wd_d[n];
            end
            digits_q <= digits_d;
            valid_q  <= valid_d;
            change_q <= change_d;
            mask_q   <= mask_d;
            an_err_q <= an_err_d;
        end
    end

    assign bus.digits       = digits_q;
    assign bus.digit_valid  = valid_q;
    assign bus.change       = change_q;
    assign bus.changed_mask = mask_q;
    assign bus.an_err       = an_err_q;
endmodule

// File: tb/tb_seven_segment_capture.sv
// Randomized and directed bench for seven_segment_capture against a
// dwell-level behavioural model with edge-timed commits and expiries.
module tb_seven_segment_capture;
    localparam int SETTLE  = 4;
    localparam int CONFIRM = 2;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    seven_segment_capture_if ifc ();

    seven_segment_capture #(
        .SETTLE (SETTLE),
        .CONFIRM(CONFIRM),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulses   = 0;
    int errs     = 0;
    bit armed    = 0;
    logic [3:0] mask_acc = 4'h0;

    logic [6:0] pats [13] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0001100, 7'b1111110, 7'b1111111,
                              7'b1010101};
    logic [3:0] codes [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                               4'h7, 4'h8, 4'h9, 4'hE, 4'hB};

    logic [3:0] mdig   [4];
    bit         mvalid [4];
    logic [3:0] mcand  [4];
    int         mconf  [4];
    int         mlast  [4];
    bit         malive [4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (armed) begin
            if (ifc.change === 1'b1) begin
                pulses++;
                mask_acc |= ifc.changed_mask;
            end else begin
                chk("mask_idle", {28'h0, ifc.changed_mask}, 32'h0);
            end
            if (ifc.an_err === 1'b1) errs++;
        end
    end

    function automatic logic [3:0] dec(input logic [6:0] s);
        for (int i = 0; i < 12; i++)
            if (pats[i] == s) return codes[i];
        return 4'hF;
    endfunction

    function automatic logic [15:0] exp_digits();
        logic [15:0] r;
        for (int n = 0; n < 4; n++) r[4*n +: 4] = mdig[n];
        return r;
    endfunction

    function automatic logic [3:0] exp_valid();
        logic [3:0] r;
        for (int n = 0; n < 4; n++) r[n] = mvalid[n];
        return r;
    endfunction

    task automatic do_reset(input string tag);
        rst = 1'b1;
        ifc.an_in  = 4'hF;
        ifc.seg_in = 7'h7F;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            mdig[n] = 4'hF; mvalid[n] = 0; mcand[n] = 4'h0;
            mconf[n] = 0; mlast[n] = cyc; malive[n] = 0;
        end
        armed = 1;
        chk({tag, "_dig"}, {16'h0, ifc.digits}, 32'hFFFF);
        chk({tag, "_val"}, {28'h0, ifc.digit_valid}, 32'h0);
        chk({tag, "_chg"}, {31'h0, ifc.change}, 32'h0);
        chk({tag, "_mask"}, {28'h0, ifc.changed_mask}, 32'h0);
        chk({tag, "_err"}, {31'h0, ifc.an_err}, 32'h0);
    endtask

    // One dwell of len cycles followed by gap blank cycles, then compare
    task automatic window(input logic [3:0] an, input logic [6:0] seg,
                          input int len, input int gap, input string tag);
        int s, e, c, d, x, exp_err;
        bit cap;
        logic [3:0] code, em;
        logic [3:0] ev [int];
        s = cyc + 1;
        e = s + len + gap - 1;
        pulses = 0; errs = 0; mask_acc = 4'h0;
        ifc.an_in = an; ifc.seg_in = seg;
        repeat (len) @(negedge clk);
        ifc.an_in = 4'hF; ifc.seg_in = 7'h7F;
        repeat (gap) @(negedge clk);

        cap = 0; d = -1; exp_err = 0; c = s + SETTLE + 1;
        code = dec(seg);
        if (len > SETTLE && an != 4'hF) begin
            if ($countones(~an) == 1) begin
                cap = 1;
                for (int n = 0; n < 4; n++) if (!an[n]) d = n;
            end else begin
                exp_err = 1;
            end
        end
        for (int n = 0; n < 4; n++) begin
            x = mlast[n] + TIMEOUT;
            if (malive[n] && x >= s && x <= e && !(cap && n == d && x >= c)) begin
                if (mvalid[n]) begin
                    em = ev.exists(x) ? ev[x] : 4'h0;
                    ev[x] = em | (4'h1 << n);
                end
                mdig[n] = 4'hF; mvalid[n] = 0; mcand[n] = 4'h0;
                mconf[n] = 0; malive[n] = 0;
            end
        end
        if (cap) begin
            if (code == mcand[d]) begin
                if (mconf[d] < CONFIRM) mconf[d]++;
            end else begin
                mcand[d] = code; mconf[d] = 1;
            end
            if (mconf[d] == CONFIRM) begin
                if (!mvalid[d] || mdig[d] != code) begin
                    em = ev.exists(c) ? ev[c] : 4'h0;
                    ev[c] = em | (4'h1 << d);
                end
                mdig[d] = code; mvalid[d] = 1;
            end
            mlast[d] = c; malive[d] = 1;
        end
        em = 4'h0;
        foreach (ev[k]) em |= ev[k];

        chk({tag, "_dig"}, {16'h0, ifc.digits}, {16'h0, exp_digits()});
        chk({tag, "_val"}, {28'h0, ifc.digit_valid}, {28'h0, exp_valid()});
        chk({tag, "_chg"}, pulses, ev.num());
        chk({tag, "_mask"}, {28'h0, mask_acc}, {28'h0, em});
        chk({tag, "_err"}, errs, exp_err);
    endtask

    initial begin
        int sel [4];
        int d, len, gap, idx;
        logic [3:0] an;
        logic [6:0] seg;
        sel = '{1, 4, 10, 12};
        ifc.an_in  = 4'hF;
        ifc.seg_in = 7'h7F;
        @(negedge clk);
        do_reset("rst0");

        for (int i = 0; i < 3; i++) window(4'b1110, pats[2], 8, 4, "t2");
        chk("t2_digit0", {28'h0, ifc.digits[3:0]}, 32'h2);

        for (int i = 0; i < 4; i++) window(4'b1101, pats[1], 3, 3, "t3");

        for (int i = 0; i < 13; i++) begin
            window(4'b1101, pats[i], 8, 4, "t4a");
            window(4'b1101, pats[i], 8, 4, "t4b");
            chk("t4_sweep", {28'h0, ifc.digits[7:4]},
                (i < 12) ? {28'h0, codes[i]} : 32'hF);
        end

        window(4'b1100, pats[8], 8, 4, "t5");

        window(4'b0111, pats[7], 8, 4, "t6c3");
        window(4'b0111, pats[7], 8, 4, "t6c3");
        window(4'b1110, pats[9], 8, 4, "t6c0");
        window(4'b1110, pats[9], 8, 4, "t6c0");
        for (int i = 0; i < 6; i++) window(4'b1110, pats[9], 8, 12, "t6r");
        chk("t6_val3", {31'h0, ifc.digit_valid[3]}, 32'h0);
        chk("t6_dig3", {28'h0, ifc.digits[15:12]}, 32'hF);
        chk("t6_val0", {31'h0, ifc.digit_valid[0]}, 32'h1);

        for (int i = 0; i < 6; i++)
            window(4'b1011, (i % 2) ? pats[6] : pats[5], 8, 4, "t7");
        chk("t7_val2", {31'h0, ifc.digit_valid[2]}, 32'h0);

        window(4'b1110, pats[3], 8, 4, "t1a");
        window(4'b1110, pats[3], 8, 4, "t1a");
        window(4'b1110, pats[4], 8, 4, "t1b");
        ifc.an_in = 4'b1110; ifc.seg_in = pats[4];
        repeat (3) @(negedge clk);
        do_reset("t1rst");
        window(4'b1110, pats[4], 8, 4, "t1c");

        for (int it = 0; it < 80; it++) begin
            d = -1;
            for (int n = 0; n < 3; n++)
                if (d < 0 && cyc - mlast[n] > 16) d = n;
            len = ($urandom_range(0, 3) == 0) ? 3 : 8;
            if (d >= 0) len = 8;
            else d = $urandom_range(0, 2);
            an = 4'hF;
            an[d] = 1'b0;
            idx = $urandom_range(0, 3);
            seg = pats[sel[idx]];
            if ($urandom_range(0, 7) == 0) seg = 7'($urandom);
            if (len == 3 && $urandom_range(0, 3) == 0) begin
                an = 4'b0101;
                len = 8;
            end
            gap = $urandom_range(1, 4);
            window(an, seg, len, gap, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
